// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: function codes,
// controller states and a width helper for the divider iteration counter.
package arith_pkg;

  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/arith_unit_seq_if.sv
// Request/result bundle of the arithmetic unit; the requester holds the
// master side, the unit the slave side.
interface arith_unit_seq_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int OUT_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [1:0]            ALU_FUNC;
  logic                  Signed_Mode;
  logic                  In_Valid;
  logic                  In_Ready;
  logic [OUT_WIDTH-1:0]  Arith_OUT;
  logic                  Carry_OUT;
  logic                  Div_Zero;
  logic                  Out_Valid;

  modport master (
    output A, B, ALU_FUNC, Signed_Mode, In_Valid,
    input  In_Ready, Arith_OUT, Carry_OUT, Div_Zero, Out_Valid
  );

  modport slave (
    input  A, B, ALU_FUNC, Signed_Mode, In_Valid,
    output In_Ready, Arith_OUT, Carry_OUT, Div_Zero, Out_Valid
  );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider core: start loads operands, then W iterations
// produce one quotient bit each; last_o flags the final iteration cycle.
module seq_divider
  import arith_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = clog2(W);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [W:0]    shifted;
  logic [W:0]    trial;

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    shifted = {rem_q, quot_q[W-1]};
    // bit W of the trial difference is the borrow: set means restore
    trial   = shifted - {1'b0, dvsr_q};
    last_o  = busy_q && (cnt_q == '0);
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(W - 1);
      quot_d = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (busy_q) begin
      rem_d  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      quot_d = {quot_q[W-2:0], ~trial[W]};
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/arith_unit_seq.sv
// Registered add/sub/mul/div unit with signed/unsigned mode and a valid/ready
// request handshake; divides run on the seq_divider core over magnitudes.
//   state | meaning
//   IDLE  | ready; add/sub/mul and divide-by-zero complete at the accept edge
//   BUSY  | divider core iterating, one quotient bit per cycle
//   FIXUP | restore quotient/remainder signs and publish the divide result
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input logic             CLK,
  input logic             RST,
  arith_unit_seq_if.slave bus
);
  localparam int W         = DATA_WIDTH;
  localparam int OUT_WIDTH = 2 * DATA_WIDTH;

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] arith_q, arith_d;
  logic                 carry_q, carry_d;
  logic                 dz_q, dz_d;
  logic                 valid_q, valid_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 sdiv_q, sdiv_d;

  logic                 smode;
  logic [W:0]           a_ext, b_ext, sum;
  logic [OUT_WIDTH-1:0] a_mul, b_mul, prod;
  logic [W-1:0]         a_mag, b_mag;
  logic [W-1:0]         div_quot, div_rem, quot_fix, rem_fix;
  logic                 div_start, div_last;

  assign smode = bus.Signed_Mode;
  assign a_ext = {smode & bus.A[W-1], bus.A};
  assign b_ext = {smode & bus.B[W-1], bus.B};
  assign sum   = (bus.ALU_FUNC == FUNC_SUB) ? a_ext - b_ext : a_ext + b_ext;
  // low 2W bits of the extended product are correct for both modes
  assign a_mul = {{W{smode & bus.A[W-1]}}, bus.A};
  assign b_mul = {{W{smode & bus.B[W-1]}}, bus.B};
  assign prod  = a_mul * b_mul;

  assign a_mag    = (smode && bus.A[W-1]) ? -bus.A : bus.A;
  assign b_mag    = (smode && bus.B[W-1]) ? -bus.B : bus.B;
  assign quot_fix = qneg_q ? -div_quot : div_quot;
  assign rem_fix  = rneg_q ? -div_rem : div_rem;

  seq_divider #(.W(W)) u_div (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .start_i    (div_start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    arith_d   = arith_q;
    carry_d   = carry_q;
    dz_d      = dz_q;
    valid_d   = 1'b0;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    sdiv_d    = sdiv_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.In_Valid) begin
          unique case (bus.ALU_FUNC)
            FUNC_ADD, FUNC_SUB: begin
              valid_d = 1'b1;
              dz_d    = 1'b0;
              arith_d = smode ? {{(W-1){sum[W]}}, sum} : {{(W-1){1'b0}}, sum};
              carry_d = smode ? (sum[W] ^ sum[W-1]) : sum[W];
            end
            FUNC_MUL: begin
              valid_d = 1'b1;
              dz_d    = 1'b0;
              arith_d = prod;
              carry_d = smode ? !((&prod[OUT_WIDTH-1:W-1]) || !(|prod[OUT_WIDTH-1:W-1]))
                              : (|prod[OUT_WIDTH-1:W]);
            end
            default: begin
              if (bus.B == '0) begin
                valid_d = 1'b1;
                dz_d    = 1'b1;
                carry_d = 1'b0;
                arith_d = {bus.A, {W{1'b1}}};
              end else begin
                div_start = 1'b1;
                qneg_d    = smode & (bus.A[W-1] ^ bus.B[W-1]);
                rneg_d    = smode & bus.A[W-1];
                sdiv_d    = smode;
                state_d   = BUSY;
              end
            end
          endcase
        end
      end
      BUSY: begin
        if (div_last) state_d = FIXUP;
      end
      FIXUP: begin
        valid_d = 1'b1;
        dz_d    = 1'b0;
        arith_d = {rem_fix, quot_fix};
        // only -2^(W-1) / -1 yields a positive quotient with the top bit set
        carry_d = sdiv_q && !qneg_q && div_quot[W-1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      arith_q <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      sdiv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arith_q <= arith_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      sdiv_q  <= sdiv_d;
    end
  end

  assign bus.In_Ready  = (state_q == IDLE);
  assign bus.Arith_OUT = arith_q;
  assign bus.Carry_OUT = carry_q;
  assign bus.Div_Zero  = dz_q;
  assign bus.Out_Valid = valid_q;

endmodule

// File: tb/tb_arith_unit_seq.sv
// Directed bench for arith_unit_seq at W = 16: vector table plus hand-written
// back-to-back, held-request and mid-divide reset sequences.
module tb_arith_unit_seq;
  import arith_pkg::*;

  localparam int W       = 16;
  localparam int DIV_LAT = W + 1;
  localparam int NV      = 17;

  typedef struct {
    logic [1:0]  func;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out;
    logic        c;
    logic        dz;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  vec_t vecs[NV];

  arith_unit_seq_if #(.DATA_WIDTH(W)) bus ();

  arith_unit_seq #(.DATA_WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int idx, input vec_t v);
    int guard;
    int lat;
    int rdy_bad;
    @(negedge clk);
    bus.A           = v.a;
    bus.B           = v.b;
    bus.ALU_FUNC    = v.func;
    bus.Signed_Mode = v.sm;
    bus.In_Valid    = 1'b1;
    guard = 0;
    while (!bus.In_Ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.In_Valid = 1'b0;
    lat     = 0;
    rdy_bad = 0;
    while (!bus.Out_Valid && lat < 40) begin
      if (bus.In_Ready) rdy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d Arith_OUT", idx), bus.Arith_OUT, v.out);
    chk($sformatf("v%0d Carry_OUT", idx), 32'(bus.Carry_OUT), 32'(v.c));
    chk($sformatf("v%0d Div_Zero", idx), 32'(bus.Div_Zero), 32'(v.dz));
    chk($sformatf("v%0d In_Ready low while busy", idx), 32'(rdy_bad), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d Out_Valid single pulse", idx), 32'(bus.Out_Valid), 32'd0);
    chk($sformatf("v%0d result held", idx), bus.Arith_OUT, v.out);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    n_chk = 0;
    n_err = 0;
    //              func      sm    a         b         out            c     dz    lat
    vecs[0]  = '{FUNC_ADD, 1'b0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b1, 1'b0, 0};
    vecs[1]  = '{FUNC_SUB, 1'b1, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 1'b1, 1'b0, 0};
    vecs[2]  = '{FUNC_MUL, 1'b1, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0, 1'b0, 0};
    vecs[3]  = '{FUNC_DIV, 1'b1, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 1'b0, DIV_LAT};
    vecs[4]  = '{FUNC_DIV, 1'b0, 16'h1234, 16'h0000, 32'h1234_FFFF, 1'b0, 1'b1, 0};
    vecs[5]  = '{FUNC_DIV, 1'b1, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1, 1'b0, DIV_LAT};
    vecs[6]  = '{FUNC_ADD, 1'b1, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b1, 1'b0, 0};
    vecs[7]  = '{FUNC_SUB, 1'b0, 16'h0003, 16'h0005, 32'h0001_FFFE, 1'b1, 1'b0, 0};
    vecs[8]  = '{FUNC_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b0, 0};
    vecs[9]  = '{FUNC_MUL, 1'b1, 16'h0100, 16'h0080, 32'h0000_8000, 1'b1, 1'b0, 0};
    vecs[10] = '{FUNC_DIV, 1'b0, 16'h0064, 16'h0007, 32'h0002_000E, 1'b0, 1'b0, DIV_LAT};
    vecs[11] = '{FUNC_DIV, 1'b1, 16'h0007, 16'hFFFE, 32'h0001_FFFD, 1'b0, 1'b0, DIV_LAT};
    vecs[12] = '{FUNC_DIV, 1'b0, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 1'b0, DIV_LAT};
    vecs[13] = '{FUNC_ADD, 1'b0, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b0, 0};
    vecs[14] = '{FUNC_DIV, 1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0};
    vecs[15] = '{FUNC_MUL, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b1, 1'b0, 0};
    vecs[16] = '{FUNC_DIV, 1'b1, 16'h8000, 16'h0001, 32'h0000_8000, 1'b0, 1'b0, DIV_LAT};

    bus.A           = '0;
    bus.B           = '0;
    bus.ALU_FUNC    = FUNC_ADD;
    bus.Signed_Mode = 1'b0;
    bus.In_Valid    = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset Arith_OUT", bus.Arith_OUT, 32'h0);
    chk("reset Carry_OUT", 32'(bus.Carry_OUT), 32'd0);
    chk("reset Div_Zero", 32'(bus.Div_Zero), 32'd0);
    chk("reset Out_Valid", 32'(bus.Out_Valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("In_Ready after reset", 32'(bus.In_Ready), 32'd1);

    for (int i = 0; i < NV; i++) do_op(i, vecs[i]);

    // back-to-back unsigned adds, one accepted per cycle
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.A           = 16'(i * 3);
      bus.B           = 16'(i + 1);
      bus.ALU_FUNC    = FUNC_ADD;
      bus.Signed_Mode = 1'b0;
      bus.In_Valid    = 1'b1;
      @(posedge clk);
      #1;
      if (bus.Out_Valid) pulses++;
      chk($sformatf("b2b add %0d", i), bus.Arith_OUT, 32'(i * 4 + 1));
    end
    @(negedge clk);
    bus.In_Valid = 1'b0;
    chk("b2b pulse count", 32'(pulses), 32'd8);

    // request held during a divide is taken once the unit is idle again
    @(negedge clk);
    bus.A           = 16'h0064;
    bus.B           = 16'h0007;
    bus.ALU_FUNC    = FUNC_DIV;
    bus.Signed_Mode = 1'b0;
    bus.In_Valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.A        = 16'h0010;
    bus.B        = 16'h0020;
    bus.ALU_FUNC = FUNC_ADD;
    for (int k = 1; k <= DIV_LAT + 1; k++) begin
      @(posedge clk);
      #1;
      if (k < DIV_LAT) begin
        chk($sformatf("held k%0d Out_Valid", k), 32'(bus.Out_Valid), 32'd0);
        chk($sformatf("held k%0d In_Ready", k), 32'(bus.In_Ready), 32'd0);
      end else if (k == DIV_LAT) begin
        chk("held div Out_Valid", 32'(bus.Out_Valid), 32'd1);
        chk("held div result", bus.Arith_OUT, 32'h0002_000E);
        chk("held In_Ready after fixup", 32'(bus.In_Ready), 32'd1);
      end else begin
        chk("held add Out_Valid", 32'(bus.Out_Valid), 32'd1);
        chk("held add result", bus.Arith_OUT, 32'h0000_0030);
      end
    end
    @(negedge clk);
    bus.In_Valid = 1'b0;

    // reset asserted in the middle of a divide
    @(negedge clk);
    bus.A           = 16'hFFFF;
    bus.B           = 16'h0003;
    bus.ALU_FUNC    = FUNC_DIV;
    bus.Signed_Mode = 1'b0;
    bus.In_Valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.In_Valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-div reset Arith_OUT", bus.Arith_OUT, 32'h0);
    chk("mid-div reset Carry_OUT", 32'(bus.Carry_OUT), 32'd0);
    chk("mid-div reset Div_Zero", 32'(bus.Div_Zero), 32'd0);
    chk("mid-div reset Out_Valid", 32'(bus.Out_Valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (bus.Out_Valid) pulses++;
    end
    chk("aborted divide Out_Valid count", 32'(pulses), 32'd0);
    do_op(NV, '{FUNC_ADD, 1'b0, 16'h0102, 16'h0304, 32'h0000_0406, 1'b0, 1'b0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
